// File: rtl/line_buffer_sched_if.sv
// Pixel-stream input and row-buffer control bundle for line_buffer_sched.
interface line_buffer_sched_if #(
    parameter int NUM_BUF = 4,
    parameter int CW      = 10
);
    localparam int PW = (NUM_BUF > 1) ? $clog2(NUM_BUF) : 1;

    logic               pix_valid;
    logic               pix_sof;
    logic [NUM_BUF-1:0] wr_en;
    logic [NUM_BUF-1:0] rd_en;
    logic [PW-1:0]      oldest_sel;
    logic [CW-1:0]      col_idx;
    logic [CW-1:0]      row_idx;
    logic               win_valid;
    logic               frame_done;
    logic               sof_err;

    // Camera side drives the stream and observes the scheduler outputs.
    modport master (
        output pix_valid, pix_sof,
        input  wr_en, rd_en, oldest_sel, col_idx, row_idx, win_valid, frame_done, sof_err
    );

    // Scheduler side.
    modport slave (
        input  pix_valid, pix_sof,
        output wr_en, rd_en, oldest_sel, col_idx, row_idx, win_valid, frame_done, sof_err
    );
endinterface

// File: rtl/line_buffer_sched.sv
// Row-buffer scheduler for the 5x5 edge-detection window.
//
// state | meaning
// IDLE  | waiting for a start-of-frame pixel
// FILL  | first rows of the frame, buffers not yet all holding data
// RUN   | steady state, windows become valid from column KSIZE-1
// DONE  | one cycle after the last pixel, frame_done pulse
//
// pos_* hold the position of the next pixel to arrive; the registered
// outputs describe the pixel accepted on the previous edge.
module line_buffer_sched #(
    parameter int IMG_W   = 640,
    parameter int IMG_H   = 480,
    parameter int NUM_BUF = 4,
    parameter int KSIZE   = 5,
    parameter int CW      = 10
) (
    input logic                clk,
    input logic                reset,
    line_buffer_sched_if.slave bus
);
    localparam int PW = (NUM_BUF > 1) ? $clog2(NUM_BUF) : 1;
    localparam logic [CW-1:0]      COL_LAST  = CW'(IMG_W - 1);
    localparam logic [CW-1:0]      ROW_LAST  = CW'(IMG_H - 1);
    localparam logic [CW-1:0]      WIN_START = CW'(KSIZE - 1);
    localparam logic [CW-1:0]      BUF_FULL  = CW'(NUM_BUF);
    localparam logic [PW-1:0]      PTR_LAST  = PW'(NUM_BUF - 1);
    localparam logic [NUM_BUF-1:0] ONE       = NUM_BUF'(1);

    typedef enum logic [1:0] {IDLE, FILL, RUN, DONE} state_t;

    state_t        state;
    logic [CW-1:0] pos_col;
    logic [CW-1:0] pos_row;
    logic [PW-1:0] pos_ptr;
    logic [PW-1:0] pos_old;

    logic               col_wrap;
    logic               last_pix;
    logic [CW-1:0]      nxt_col;
    logic [CW-1:0]      nxt_row;
    logic [PW-1:0]      nxt_ptr;
    logic [PW-1:0]      nxt_old;
    logic [NUM_BUF-1:0] wr_cur;
    logic [NUM_BUF-1:0] rd_cur;

    // Position advance and buffer enables for the pixel at pos_*.
    always_comb begin
        col_wrap = (pos_col == COL_LAST);
        last_pix = col_wrap && (pos_row == ROW_LAST);
        nxt_col  = col_wrap ? '0 : pos_col + CW'(1);
        nxt_row  = col_wrap ? pos_row + CW'(1) : pos_row;
        nxt_ptr  = pos_ptr;
        nxt_old  = pos_old;
        if (col_wrap) begin
            nxt_ptr = (pos_ptr == PTR_LAST) ? '0 : pos_ptr + PW'(1);
            // The oldest row only starts moving once every buffer has been filled.
            if (pos_row >= BUF_FULL) begin
                nxt_old = (pos_old == PTR_LAST) ? '0 : pos_old + PW'(1);
            end
        end
        wr_cur = ONE << pos_ptr;
        // While filling, only buffers below the write pointer hold a row.
        rd_cur = (pos_row < BUF_FULL) ? ((ONE << pos_row) - ONE) : ~wr_cur;
    end

    // Frame FSM with registered outputs.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state          <= IDLE;
            pos_col        <= '0;
            pos_row        <= '0;
            pos_ptr        <= '0;
            pos_old        <= '0;
            bus.wr_en      <= '0;
            bus.rd_en      <= '0;
            bus.oldest_sel <= '0;
            bus.col_idx    <= '0;
            bus.row_idx    <= '0;
            bus.win_valid  <= 1'b0;
            bus.frame_done <= 1'b0;
            bus.sof_err    <= 1'b0;
        end else begin
            bus.wr_en      <= '0;
            bus.rd_en      <= '0;
            bus.win_valid  <= 1'b0;
            bus.frame_done <= 1'b0;
            case (state)
                IDLE, FILL, RUN: begin
                    if (bus.pix_valid) begin
                        if (bus.pix_sof) begin
                            // First pixel of a (possibly restarted) frame lands at (0,0) in buffer 0.
                            state          <= FILL;
                            bus.col_idx    <= '0;
                            bus.row_idx    <= '0;
                            bus.oldest_sel <= '0;
                            bus.wr_en      <= ONE;
                            pos_col        <= CW'(1);
                            pos_row        <= '0;
                            pos_ptr        <= '0;
                            pos_old        <= '0;
                        end else if (state == IDLE) begin
                            bus.sof_err <= 1'b1;
                        end else begin
                            bus.col_idx    <= pos_col;
                            bus.row_idx    <= pos_row;
                            bus.oldest_sel <= pos_old;
                            bus.wr_en      <= wr_cur;
                            bus.rd_en      <= rd_cur;
                            bus.win_valid  <= (pos_row >= WIN_START) && (pos_col >= WIN_START);
                            state          <= (pos_row >= WIN_START) ? RUN : FILL;
                            if (last_pix) begin
                                state   <= DONE;
                                pos_col <= '0;
                                pos_row <= '0;
                                pos_ptr <= '0;
                                pos_old <= '0;
                            end else begin
                                pos_col <= nxt_col;
                                pos_row <= nxt_row;
                                pos_ptr <= nxt_ptr;
                                pos_old <= nxt_old;
                            end
                        end
                    end
                end
                DONE: begin
                    bus.frame_done <= 1'b1;
                    bus.col_idx    <= '0;
                    bus.row_idx    <= '0;
                    bus.oldest_sel <= '0;
                    state          <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_line_buffer_sched.sv
// Directed bench for line_buffer_sched on a reduced 8x7 image.
module tb_line_buffer_sched;
    localparam int W = 8;
    localparam int H = 7;
    localparam int NB = 4;
    localparam int K = 5;
    localparam int CW = 10;
    localparam int EXP_WIN = (W - (K - 1)) * (H - (K - 1));

    logic clk = 1'b0;
    logic reset = 1'b0;
    int   n_cmp = 0;
    int   n_err = 0;
    int   win_seen = 0;

    line_buffer_sched_if #(.NUM_BUF(NB), .CW(CW)) bus();

    line_buffer_sched #(
        .IMG_W(W), .IMG_H(H), .NUM_BUF(NB), .KSIZE(K), .CW(CW)
    ) dut (
        .clk(clk),
        .reset(reset),
        .bus(bus.slave)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic       v;
        logic       s;
        logic [9:0] col;
        logic [9:0] row;
        logic [3:0] wr;
        logic [3:0] rd;
        logic [1:0] old;
        logic       win;
    } vec_t;

    vec_t vecs[8];

    function automatic logic [32:0] pk(input logic [9:0] c, input logic [9:0] r,
                                       input logic [3:0] w, input logic [3:0] rd,
                                       input logic [1:0] o, input logic win,
                                       input logic fd, input logic err);
        return {c, r, w, rd, o, win, fd, err};
    endfunction

    function automatic logic [32:0] obs();
        return {bus.col_idx, bus.row_idx, bus.wr_en, bus.rd_en, bus.oldest_sel,
                bus.win_valid, bus.frame_done, bus.sof_err};
    endfunction

    // Expected outputs for the k-th pixel of a frame (raster order).
    function automatic logic [32:0] exp_pix(input int k);
        int row;
        int col;
        logic [3:0] w;
        logic [3:0] rd;
        logic [1:0] o;
        row = k / W;
        col = k % W;
        w   = 4'b0001 << (row % NB);
        rd  = (row < NB) ? ((4'b0001 << row) - 4'b0001) : ~w;
        o   = (row <= NB) ? 2'd0 : 2'((row - NB) % NB);
        return pk(10'(col), 10'(row), w, rd, o, (row >= K - 1) && (col >= K - 1), 1'b0, 1'b0);
    endfunction

    task automatic chk(input string name, input logic [32:0] act, input logic [32:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic send(input logic v, input logic s);
        bus.pix_valid = v;
        bus.pix_sof   = s;
        @(posedge clk);
        #1;
    endtask

    // Streams pixels k0..k1-1 of a frame (k==0 carries sof), optionally with random gaps.
    task automatic run_pixels(input int k0, input int k1, input bit gap);
        for (int k = k0; k < k1; k++) begin
            if (gap && k > 0 && $urandom_range(0, 1) == 1) begin
                send(1'b0, 1'($urandom_range(0, 1)));
                chk("gap_hold", obs(), exp_pix(k - 1) & ~pk(0, 0, 4'hF, 4'hF, 0, 1'b1, 0, 0));
            end
            send(1'b1, k == 0);
            chk("pixel", obs(), exp_pix(k));
            if (bus.win_valid === 1'b1) win_seen++;
            if (k == 5 * W + 7)
                chk("row5_last", {23'd0, bus.col_idx}, {23'd0, 10'd7});
            if (k == 5 * W + 7)
                chk("row5_wr", {29'd0, bus.wr_en}, {29'd0, 4'b0010});
            if (k == 6 * W)
                chk("row6_first", {9'd0, bus.col_idx, bus.row_idx, bus.wr_en},
                    {9'd0, 10'd0, 10'd6, 4'b0100});
            if (k == 6 * W)
                chk("row6_oldest", {31'd0, bus.oldest_sel}, {31'd0, 2'd2});
        end
    endtask

    task automatic end_frame();
        send(1'b0, 1'b0);
        chk("frame_done_pulse", obs(), pk(0, 0, 0, 0, 0, 1'b0, 1'b1, 1'b0));
        send(1'b0, 1'b0);
        chk("frame_done_clear", obs(), pk(0, 0, 0, 0, 0, 1'b0, 1'b0, 1'b0));
    endtask

    initial begin
        vecs[0] = '{1'b0, 1'b1, 10'd0, 10'd0, 4'b0000, 4'b0000, 2'd0, 1'b0};
        vecs[1] = '{1'b1, 1'b1, 10'd0, 10'd0, 4'b0001, 4'b0000, 2'd0, 1'b0};
        vecs[2] = '{1'b1, 1'b0, 10'd1, 10'd0, 4'b0001, 4'b0000, 2'd0, 1'b0};
        vecs[3] = '{1'b0, 1'b0, 10'd1, 10'd0, 4'b0000, 4'b0000, 2'd0, 1'b0};
        vecs[4] = '{1'b0, 1'b1, 10'd1, 10'd0, 4'b0000, 4'b0000, 2'd0, 1'b0};
        vecs[5] = '{1'b1, 1'b0, 10'd2, 10'd0, 4'b0001, 4'b0000, 2'd0, 1'b0};
        vecs[6] = '{1'b1, 1'b1, 10'd0, 10'd0, 4'b0001, 4'b0000, 2'd0, 1'b0};
        vecs[7] = '{1'b1, 1'b0, 10'd1, 10'd0, 4'b0001, 4'b0000, 2'd0, 1'b0};

        bus.pix_valid = 1'b0;
        bus.pix_sof   = 1'b0;

        // Reset held with random traffic.
        for (int i = 0; i < 10; i++) begin
            bus.pix_valid = 1'($urandom_range(0, 1));
            bus.pix_sof   = 1'($urandom_range(0, 1));
            @(posedge clk);
            #1;
            chk("reset_hold", obs(), '0);
        end
        bus.pix_valid = 1'b0;
        bus.pix_sof   = 1'b0;
        reset = 1'b1;

        // Short directed vectors: ignored sof, start, gaps, restart from FILL.
        for (int i = 0; i < 8; i++) begin
            send(vecs[i].v, vecs[i].s);
            chk($sformatf("vec%0d", i), obs(),
                pk(vecs[i].col, vecs[i].row, vecs[i].wr, vecs[i].rd, vecs[i].old,
                   vecs[i].win, 1'b0, 1'b0));
        end

        // Full continuous frame (restarts from FILL at its first pixel).
        win_seen = 0;
        run_pixels(0, W * H, 1'b0);
        chk("win_count_cont", 33'(win_seen), 33'(EXP_WIN));
        end_frame();

        // Gapped frame from IDLE.
        win_seen = 0;
        run_pixels(0, W * H, 1'b1);
        chk("win_count_gap", 33'(win_seen), 33'(EXP_WIN));
        end_frame();

        // Mid-frame sof at row 5 col 3: frame restarts, no frame_done in between.
        run_pixels(0, 5 * W + 4, 1'b0);
        win_seen = 0;
        run_pixels(0, W * H, 1'b0);
        chk("win_count_restart", 33'(win_seen), 33'(EXP_WIN));
        end_frame();

        // sof_err: pixel without sof in IDLE, sticky until reset.
        send(1'b1, 1'b0);
        chk("sof_err_set", obs(), pk(0, 0, 0, 0, 0, 1'b0, 1'b0, 1'b1));
        send(1'b0, 1'b0);
        chk("sof_err_sticky", obs(), pk(0, 0, 0, 0, 0, 1'b0, 1'b0, 1'b1));
        send(1'b1, 1'b1);
        chk("sof_err_new_frame", obs(), pk(0, 0, 4'b0001, 0, 0, 1'b0, 1'b0, 1'b1));
        send(1'b1, 1'b0);
        chk("sof_err_pixel", obs(), pk(10'd1, 0, 4'b0001, 0, 0, 1'b0, 1'b0, 1'b1));

        // Asynchronous reset mid-cycle, mid-frame.
        @(negedge clk);
        #2;
        reset = 1'b0;
        #1;
        chk("async_reset", obs(), '0);
        @(posedge clk);
        #1;
        reset = 1'b1;
        send(1'b1, 1'b0);
        chk("after_reset_idle", obs(), pk(0, 0, 0, 0, 0, 1'b0, 1'b0, 1'b1));

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
